ysyx_23060236_axi_sram_slave: RTL
=================================

// Module: ysyx_23060236_axi_sram_slave
// PURPOSE
//  AXI4 responder backed by an on-chip word SRAM; the target end of the
//  translated master port (page-table walks, fetch/LSU bursts). Serves one
//  transaction at a time with configurable read latency, INCR/FIXED bursts,
//  byte strobes, ID echo and SLVERR for out-of-range beats.
// PARAMETERS
//  MEM_WORDS     4096          depth of SRAM in 32-bit words (power of 2)
//  BASE_ADDR     32'h8000_0000 byte address mapped to word 0
//  READ_LATENCY  2             idle cycles between AR handshake and first R beat (0..15)
// PORTS
//  clock         in   1   clock
//  reset         in   1   synchronous, active-high
//  awready/awvalid out/in 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2
//  wready/wvalid out/in 1; wdata in 32; wstrb in 4; wlast in 1
//  bvalid out 1; bready in 1; bresp out 2; bid out 4
//  arready/arvalid out/in 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2
//  rvalid out 1; rready in 1; rresp out 2; rdata out 32; rlast out 1; rid out 4
// BEHAVIOUR
//  - Reset: state IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0;
//    bresp/rresp = OKAY, rdata = 0. SRAM contents are NOT cleared.
//  - States: IDLE, R_WAIT, R_DATA, W_DATA, W_RESP.
//  - IDLE: awready = arready = 1 (registered, 0 during reset cycle). If awvalid
//    and arvalid both high, write wins (arready dropped that cycle). AW/AR
//    handshake latches addr, id, len, size, burst; beat counter := 0.
//  - AR -> R_WAIT (latency counter = READ_LATENCY; if 0 go straight to R_DATA).
//    First rvalid exactly 1+READ_LATENCY cycles after AR handshake.
//  - R_DATA: rvalid=1, rid=latched arid, rdata=mem[word], rlast=(cnt==len).
//    Outputs stable while rvalid & ~rready. On handshake next beat is
//    presented the following cycle (1 beat/cycle). After rlast handshake -> IDLE.
//  - AW -> W_DATA: wready=1; per w handshake write bytes where wstrb[i]=1.
//    Ends on beat cnt==awlen -> W_RESP. wlast disagreeing with counter
//    (early or missing) sets sticky error; beats are still counted by counter.
//  - W_RESP: bvalid=1, bid=latched awid, bresp=SLVERR if any beat out of range
//    or wlast mismatch, else OKAY; held until bready -> IDLE.
//  - Address: word = (addr - BASE_ADDR) >> 2; beat out of range when
//    addr < BASE_ADDR or word >= MEM_WORDS: read returns 0 with SLVERR, write
//    dropped. Per-beat rresp; no wrap past end of SRAM.
//  - Burst: INCR adds (1<<size) per beat (32-bit arithmetic, overflow wraps);
//    FIXED keeps addr. WRAP or size>2: every beat SLVERR, no SRAM access.
//    Sub-word reads return full aligned word; masters pick lanes.
//  - awlen/arlen 0 = single beat; 255 = 256 beats, counter 8-bit, no overflow.
//  - Reset mid-transaction: abort, return to IDLE, no B/R completion issued.
// STRUCTURE
//  - Shared package: AXI resp codes (OKAY=2'b00, SLVERR=2'b10), burst codes
//    (FIXED=0, INCR=1, WRAP=2), state encoding.
//  - Sub-module ysyx_23060236_sram_array: MEM_WORDS x 32, async read, sync
//    write with 4-bit byte enable.
// TESTING
//  - Single read after reset, mem[0]=32'hDEAD_BEEF, araddr=8000_0000, arid=3,
//    READ_LATENCY=2 -> rvalid 3 cycles after AR, rdata=DEAD_BEEF, rid=3, rlast=1, OKAY.
//  - INCR write len=3 at 8000_0010 data 1..4, wstrb=F, then read len=3 ->
//    B OKAY bid echoed; R beats 1,2,3,4, rlast only on 4th; rready toggled
//    0/1 each cycle -> data held stable while stalled.
//  - Byte strobe: mem=FFFF_FFFF, write 1234_5678 wstrb=4'b0101 -> read FF34_FF78.
//  - Out of range: INCR len=1 at BASE+4*(MEM_WORDS-1) -> beat0 OKAY, beat1
//    SLVERR data 0; write same -> bresp SLVERR, last word unchanged.
//  - awvalid and arvalid same cycle -> awready=1, arready=0; read served after B.
//  - Reset asserted mid read burst (beat 2 of 8) -> next cycle rvalid=0,
//    arready=1 after reset release; memory contents intact; wlast early on
//    write len=2 beat 1 -> bresp SLVERR.

Source files
------------

// File: rtl/ysyx_23060236_axi_sram_slave_pkg.sv
// Shared AXI response/burst codes, slave FSM states and burst address helpers.
package ysyx_23060236_axi_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R_WAIT,
        S_R_DATA,
        S_W_DATA,
        S_W_RESP
    } state_t;

    // Only FIXED/INCR bursts of at most 4 bytes per beat are served.
    function automatic logic beat_fmt_ok(input logic [1:0] burst, input logic [2:0] size);
        return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size <= 3'd2);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                              input logic [2:0] size);
        return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
    endfunction

endpackage

// File: rtl/ysyx_23060236_sram_array.sv
// Word SRAM: combinational read, synchronous byte-enabled write. Contents have no reset.
module ysyx_23060236_sram_array #(
    parameter int WORDS = 4096,
    parameter int AW    = 12
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clock) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ysyx_23060236_axi_sram_slave.sv
// AXI4 slave over a word SRAM: one transaction at a time, INCR/FIXED bursts, byte strobes,
// per-beat SLVERR outside the SRAM window, READ_LATENCY idle cycles before the first R beat.
module ysyx_23060236_axi_sram_slave
    import ysyx_23060236_axi_sram_slave_pkg::*;
#(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        o_awready,
    input  logic        i_awvalid,
    input  logic [31:0] i_awaddr,
    input  logic [3:0]  i_awid,
    input  logic [7:0]  i_awlen,
    input  logic [2:0]  i_awsize,
    input  logic [1:0]  i_awburst,
    output logic        o_wready,
    input  logic        i_wvalid,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_wlast,
    output logic        o_bvalid,
    input  logic        i_bready,
    output logic [1:0]  o_bresp,
    output logic [3:0]  o_bid,
    output logic        o_arready,
    input  logic        i_arvalid,
    input  logic [31:0] i_araddr,
    input  logic [3:0]  i_arid,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    input  logic [1:0]  i_arburst,
    output logic        o_rvalid,
    input  logic        i_rready,
    output logic [1:0]  o_rresp,
    output logic [31:0] o_rdata,
    output logic        o_rlast,
    output logic [3:0]  o_rid
);
    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [29:0] WORD_LIM = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rdy;
    logic [31:0] r_addr;
    logic [3:0]  r_id;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_lat;
    logic        r_werr;

    logic [29:0] w_woff;
    logic        w_beat_ok;
    logic        w_last;
    logic        w_aw_hs;
    logic        w_ar_hs;
    logic        w_beat_hs;
    logic        w_mem_we;
    logic [31:0] w_mem_rdata;

    // Write wins a same-cycle AW/AR race by masking arready while awvalid is up.
    assign o_awready = r_rdy;
    assign o_arready = r_rdy & ~i_awvalid;
    assign w_aw_hs   = i_awvalid & o_awready;
    assign w_ar_hs   = i_arvalid & o_arready;

    assign w_woff    = 30'((r_addr - BASE_ADDR) >> 2);
    assign w_beat_ok = beat_fmt_ok(r_burst, r_size) && (r_addr >= BASE_ADDR) && (w_woff < WORD_LIM);
    assign w_last    = (r_cnt == r_len);
    assign w_mem_we  = (r_state == S_W_DATA) && i_wvalid && w_beat_ok;
    assign o_bid     = r_id;
    assign o_rid     = r_id;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_hs   = 1'b0;
        o_wready    = 1'b0;
        o_bvalid    = 1'b0;
        o_bresp     = RESP_OKAY;
        o_rvalid    = 1'b0;
        o_rresp     = RESP_OKAY;
        o_rdata     = '0;
        o_rlast     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs)      w_state_nxt = S_W_DATA;
                else if (w_ar_hs) w_state_nxt = (READ_LATENCY == 0) ? S_R_DATA : S_R_WAIT;
            end
            S_R_WAIT: begin
                if (r_lat <= 4'd1) w_state_nxt = S_R_DATA;
            end
            S_R_DATA: begin
                o_rvalid  = 1'b1;
                o_rresp   = w_beat_ok ? RESP_OKAY : RESP_SLVERR;
                o_rdata   = w_beat_ok ? w_mem_rdata : '0;
                o_rlast   = w_last;
                w_beat_hs = i_rready;
                if (i_rready && w_last) w_state_nxt = S_IDLE;
            end
            S_W_DATA: begin
                o_wready  = 1'b1;
                w_beat_hs = i_wvalid;
                if (i_wvalid && w_last) w_state_nxt = S_W_RESP;
            end
            S_W_RESP: begin
                o_bvalid = 1'b1;
                o_bresp  = r_werr ? RESP_SLVERR : RESP_OKAY;
                if (i_bready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdy   <= 1'b0;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_lat   <= '0;
            r_werr  <= 1'b0;
        end else begin
            r_rdy <= (w_state_nxt == S_IDLE);
            if (w_aw_hs || w_ar_hs) begin
                r_addr  <= w_aw_hs ? i_awaddr  : i_araddr;
                r_id    <= w_aw_hs ? i_awid    : i_arid;
                r_len   <= w_aw_hs ? i_awlen   : i_arlen;
                r_size  <= w_aw_hs ? i_awsize  : i_arsize;
                r_burst <= w_aw_hs ? i_awburst : i_arburst;
                r_cnt   <= '0;
                r_werr  <= 1'b0;
                r_lat   <= 4'(READ_LATENCY);
            end else if (w_beat_hs) begin
                r_cnt  <= r_cnt + 8'd1;
                r_addr <= next_addr(r_addr, r_burst, r_size);
                // The beat counter, not wlast, ends the burst; a disagreeing wlast only flags.
                if ((r_state == S_W_DATA) && (!w_beat_ok || (i_wlast != w_last))) r_werr <= 1'b1;
            end
            if (r_state == S_R_WAIT) r_lat <= r_lat - 4'd1;
        end
    end

    ysyx_23060236_sram_array #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_sram (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_be    (i_wstrb),
        .i_addr  (w_woff[AW-1:0]),
        .i_wdata (i_wdata),
        .o_rdata (w_mem_rdata)
    );

endmodule
